// File: rtl/nlfsr_prng_gen.sv
// Purpose: parametrised NLFSR pseudo-random word generator with seed handshake and lockup guard.
// Latency: STEPS+1 edges from enable sampled in IDLE to o_out_valid; one word per STEPS+1 cycles back-to-back.
// Backpressure: the word is held stable and the state is frozen until o_out_valid & i_out_ready or a new seed.
// Optional: define NLFSR_WHITEN_EN to fold the top OUT_W state bits into the output word.
module nlfsr_prng_gen #(
    parameter int                 WIDTH        = 128,
    parameter int                 OUT_W        = 64,
    parameter int                 STEPS        = 8,
    parameter logic [WIDTH-1:0]   TAP_MASK     = WIDTH'(8'hE1),
    parameter int                 AND_A        = WIDTH - 2,
    parameter int                 AND_B        = WIDTH - 3,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED = WIDTH'(1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_seed_valid,
    input  logic [WIDTH-1:0]  i_seed_data,
    output logic              o_seed_ready,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [OUT_W-1:0]  o_out_data,
    output logic [31:0]       o_word_count,
    output logic              o_busy
);

    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STEP    = 2'd1,
        ST_PRESENT = 2'd2
    } fsm_t;

    fsm_t              r_fsm;
    logic [WIDTH-1:0]  r_state;
    logic [CNT_W-1:0]  r_step_cnt;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_out_data;
    logic [31:0]       r_word_count;
    logic              r_busy;
    logic              r_seed_ready;

    logic              w_fb;
    logic [WIDTH-1:0]  w_shifted;
    logic [WIDTH-1:0]  w_step_next;
    logic [WIDTH-1:0]  w_seed_val;
    logic [OUT_W-1:0]  w_word;
    logic              w_last;

    // Next-state datapath: one NLFSR shift, lockup recovery, seed sanitising and word extraction.
    always_comb begin
        w_fb        = (^(r_state & TAP_MASK)) ^ (r_state[AND_A] & r_state[AND_B]);
        w_shifted   = {r_state[WIDTH-2:0], w_fb};
        // An all-zero state can never leave zero by shifting, so re-seed instead of shifting.
        w_step_next = (r_state == '0) ? DEFAULT_SEED : w_shifted;
        // A zero seed would lock the register up, so it is replaced by the default seed.
        w_seed_val  = (i_seed_data == '0) ? DEFAULT_SEED : i_seed_data;
`ifdef NLFSR_WHITEN_EN
        w_word      = w_step_next[OUT_W-1:0] ^ w_step_next[WIDTH-1 -: OUT_W];
`else
        w_word      = w_step_next[OUT_W-1:0];
`endif
        w_last      = (r_step_cnt == LAST_STEP);
    end

    // Control FSM with registered outputs; seeds take priority over the output handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fsm        <= ST_IDLE;
            r_state      <= DEFAULT_SEED;
            r_step_cnt   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_word_count <= '0;
            r_busy       <= 1'b0;
            r_seed_ready <= 1'b1;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (i_seed_valid) begin
                        // Seed wins over enable; enable is looked at again next cycle.
                        r_state <= w_seed_val;
                    end else if (i_enable) begin
                        r_fsm        <= ST_STEP;
                        r_step_cnt   <= '0;
                        r_busy       <= 1'b1;
                        r_seed_ready <= 1'b0;
                    end
                end

                ST_STEP: begin
                    // enable is ignored here: a started word always completes.
                    r_state    <= w_step_next;
                    r_step_cnt <= r_step_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_out_data   <= w_word;
                        r_out_valid  <= 1'b1;
                        r_fsm        <= ST_PRESENT;
                        r_busy       <= 1'b0;
                        r_seed_ready <= 1'b1;
                    end
                end

                ST_PRESENT: begin
                    if (i_seed_valid) begin
                        // Reseed discards the pending word without counting it.
                        r_state      <= w_seed_val;
                        r_out_valid  <= 1'b0;
                        r_step_cnt   <= '0;
                        r_fsm        <= ST_STEP;
                        r_busy       <= 1'b1;
                        r_seed_ready <= 1'b0;
                    end else if (i_out_ready) begin
                        if (r_word_count != 32'hFFFF_FFFF) begin
                            r_word_count <= r_word_count + 32'd1;
                        end
                        r_out_valid <= 1'b0;
                        if (i_enable) begin
                            r_step_cnt   <= '0;
                            r_fsm        <= ST_STEP;
                            r_busy       <= 1'b1;
                            r_seed_ready <= 1'b0;
                        end else begin
                            r_fsm <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_fsm        <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_seed_ready <= 1'b1;
                    r_out_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign o_seed_ready = r_seed_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_word_count = r_word_count;
    assign o_busy       = r_busy;

endmodule
